// File: rtl/mash_pkg.sv
// Shared constants and helpers for the MASH 1-1-...-1 delta-sigma modulator:
// order limits, output width rule, dither LFSR definition and cancellation weights.
package mash_pkg;

  localparam int MASH_MAX_ORDER = 4;
  localparam int LFSR_W         = 16;

  // Right-shifting Fibonacci form of taps 16,14,13,11: feedback = b0^b2^b3^b5
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK     = 16'h002D;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic int out_width(input int order);
    return order + 1;
  endfunction

  // Signed weight of c_order[n-tap] in (1-z^-1)^(order-1): (-1)^tap * C(order-1, tap)
  function automatic int binom(input int order, input int tap);
    int n;
    int c;
    n = order - 1;
    c = 1;
    if ((tap < 0) || (tap > n)) begin
      return 0;
    end
    for (int i = 0; i < tap; i++) begin
      c = (c * (n - i)) / (i + 1);
    end
    return ((tap % 2) == 1) ? -c : c;
  endfunction

endpackage

// File: rtl/mash_stage.sv
// One first-order accumulator stage: combinational sum/carry of acc + in + cin,
// with the accumulator register advancing only on enabled edges.
module mash_stage #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [BITS-1:0] in_i,
  input  logic            cin_i,
  output logic [BITS-1:0] s_o,
  output logic            c_o
);

  logic [BITS-1:0] acc_q;
  logic [BITS-1:0] acc_d;
  logic [BITS:0]   sum_s;

  always_comb begin
    sum_s = {1'b0, acc_q} + {1'b0, in_i} + {{BITS{1'b0}}, cin_i};
    s_o   = sum_s[BITS-1:0];
    c_o   = sum_s[BITS];
    if (en_i) begin
      acc_d = sum_s[BITS-1:0];
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mash_nth_order.sv
// MASH 1-1-...-1 modulator of ORDER cascaded stages with carry noise cancellation,
// frequency-word load strobe, clock enable with freeze and optional LFSR LSB dither.
module mash_nth_order
  import mash_pkg::*;
#(
  parameter int                BITS        = 8,
  parameter int                ORDER       = 3,
  parameter int                OUT_W       = out_width(ORDER),
  parameter logic [LFSR_W-1:0] DITHER_SEED = LFSR_DEFAULT_SEED
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic [BITS-1:0]         f_i,
  input  logic                    f_load_i,
  input  logic                    dither_en_i,
  output logic signed [OUT_W-1:0] dn_o,
  output logic                    valid_o
);

  if ((ORDER < 1) || (ORDER > MASH_MAX_ORDER)) begin : g_bad_order
    $error("mash_nth_order: ORDER must be in 1..%0d", MASH_MAX_ORDER);
  end
  if (OUT_W != out_width(ORDER)) begin : g_bad_out_w
    $error("mash_nth_order: OUT_W is derived from ORDER and must not be overridden");
  end
  if (DITHER_SEED == '0) begin : g_bad_seed
    $error("mash_nth_order: DITHER_SEED must be nonzero");
  end

  logic [BITS-1:0]   f_q, f_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [BITS-1:0]   chain_s [ORDER+1];
  logic              chain_unused_s;
  logic [MASH_MAX_ORDER-1:0] c_s;
  // cd_q[k][j] holds c_(k+1) from j+1 enabled edges ago
  logic [MASH_MAX_ORDER-1:0][MASH_MAX_ORDER-2:0] cd_q, cd_d;
  logic [MASH_MAX_ORDER-1:0][MASH_MAX_ORDER-1:0] hist_s;
  logic signed [OUT_W-1:0] y_s, dn_q, dn_d;
  logic valid_q;

  assign chain_s[0]     = f_q;
  assign chain_unused_s = ^chain_s[ORDER];

  for (genvar k = 0; k < MASH_MAX_ORDER; k++) begin : g_stage
    if (k < ORDER) begin : g_on
      mash_stage #(.BITS(BITS)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en_i),
        .in_i  (chain_s[k]),
        .cin_i ((k == 0) ? (dither_en_i & lfsr_q[0]) : 1'b0),
        .s_o   (chain_s[k+1]),
        .c_o   (c_s[k])
      );
    end else begin : g_off
      assign c_s[k] = 1'b0;
    end
  end

  // Y = sum over stages of (1-z^-1)^(k-1) c_k; unused stages contribute zero carries
  always_comb begin
    y_s = '0;
    for (int k = 0; k < MASH_MAX_ORDER; k++) begin
      hist_s[k] = {cd_q[k], c_s[k]};
      for (int t = 0; t < MASH_MAX_ORDER; t++) begin
        if (hist_s[k][t]) begin
          y_s = y_s + OUT_W'(binom(k + 1, t));
        end else begin
          y_s = y_s;
        end
      end
    end
  end

  // Next state: f capture is independent of en, everything else freezes when en is low
  always_comb begin
    f_d    = f_q;
    lfsr_d = lfsr_q;
    cd_d   = cd_q;
    dn_d   = dn_q;
    if (f_load_i) begin
      f_d = f_i;
    end else begin
      f_d = f_q;
    end
    if (en_i) begin
      lfsr_d = {^(lfsr_q & LFSR_TAP_MASK), lfsr_q[LFSR_W-1:1]};
      for (int k = 0; k < MASH_MAX_ORDER; k++) begin
        cd_d[k] = {cd_q[k][MASH_MAX_ORDER-3:0], c_s[k]};
      end
      dn_d = y_s;
    end else begin
      lfsr_d = lfsr_q;
      cd_d   = cd_q;
      dn_d   = dn_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q     <= '0;
      lfsr_q  <= DITHER_SEED;
      cd_q    <= '0;
      dn_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      f_q     <= f_d;
      lfsr_q  <= lfsr_d;
      cd_q    <= cd_d;
      dn_q    <= dn_d;
      valid_q <= en_i;
    end
  end

  assign dn_o    = dn_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_mash_nth_order.sv
// Directed bench for mash_nth_order: four instances (ORDER 1..4) share one stimulus
// and are checked against hand-derived sequences, sums and range bounds.
module tb_mash_nth_order;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] f = 8'd0;
  logic       f_load = 1'b0;
  logic       dither_en = 1'b0;

  logic signed [1:0] dn1;
  logic signed [2:0] dn2;
  logic signed [3:0] dn3;
  logic signed [4:0] dn4;
  logic valid1, valid2, valid3, valid4;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-derived dn sequences for f = 128 starting from reset state
  int t1 [2] = '{0, 1};
  int t2 [4] = '{0, 1, 1, 0};
  int t3 [4] = '{0, 2, -1, 1};
  int t4 [8] = '{0, 2, -1, 1, 1, -1, 2, 0};

  always #5 clk = ~clk;

  mash_nth_order #(.BITS(8), .ORDER(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .f_i(f), .f_load_i(f_load),
    .dither_en_i(dither_en), .dn_o(dn1), .valid_o(valid1));
  mash_nth_order #(.BITS(8), .ORDER(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .f_i(f), .f_load_i(f_load),
    .dither_en_i(dither_en), .dn_o(dn2), .valid_o(valid2));
  mash_nth_order #(.BITS(8), .ORDER(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .f_i(f), .f_load_i(f_load),
    .dither_en_i(dither_en), .dn_o(dn3), .valid_o(valid3));
  mash_nth_order #(.BITS(8), .ORDER(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .f_i(f), .f_load_i(f_load),
    .dither_en_i(dither_en), .dn_o(dn4), .valid_o(valid4));

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dn1"}, dn1, 0);
    chk({tag, "_dn2"}, dn2, 0);
    chk({tag, "_dn3"}, dn3, 0);
    chk({tag, "_dn4"}, dn4, 0);
    chk({tag, "_valid1"}, valid1, 0);
    chk({tag, "_valid4"}, valid4, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    en = 1'b0;
    f_load = 1'b0;
    dither_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load_f(input logic [7:0] val);
    f = val;
    f_load = 1'b1;
    en = 1'b0;
    tick();
    f_load = 1'b0;
    chk("load_valid3", valid3, 0);
  endtask

  task automatic run_table(input int first, input int count, input string tag);
    for (int i = first; i < first + count; i++) begin
      tick();
      chk({tag, "_d1"}, dn1, t1[i % 2]);
      chk({tag, "_d2"}, dn2, t2[i % 4]);
      chk({tag, "_d3"}, dn3, t3[i % 4]);
      chk({tag, "_d4"}, dn4, t4[i % 8]);
      chk({tag, "_valid"}, valid3, 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int sum1, sum2, sum3, sum4, last2, dcount, c1sum;
    logic [15:0] lfsr;

    // Asynchronous reset with no clock edge seen yet
    #3;
    chk_all_zero("reset");
    #4;
    rst_n = 1'b1;

    // f_q = 0, no dither: all carries stay zero
    en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("zero_dn1", dn1, 0);
      chk("zero_dn2", dn2, 0);
      chk("zero_dn3", dn3, 0);
      chk("zero_dn4", dn4, 0);
      chk("zero_valid", valid3, 1);
    end

    // f = 128 sequences
    load_f(8'd128);
    chk("load_dn3_hold", dn3, 0);
    en = 1'b1;
    run_table(0, 8, "seq");

    // Freeze for 5 cycles, then the sequence must continue without a gap
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid1", valid1, 0);
      chk("hold_valid4", valid4, 0);
      chk("hold_dn1", dn1, t1[1]);
      chk("hold_dn2", dn2, t2[3]);
      chk("hold_dn3", dn3, t3[3]);
      chk("hold_dn4", dn4, t4[7]);
    end
    en = 1'b1;
    run_table(8, 8, "resume");

    // Mid-run reset, then the post-reset run repeats the first sequence
    pulse_reset();
    load_f(8'd128);
    en = 1'b1;
    run_table(0, 8, "post_rst");

    // f = 64; changing f without f_load must not matter
    pulse_reset();
    load_f(8'd64);
    en = 1'b1;
    sum1 = 0;
    sum2 = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) f = 8'd200;
      tick();
      sum1 += int'(dn1);
      sum2 += int'(dn2);
    end
    chk("f64_sum1", sum1, 64);
    chk("f64_sum2_in_range", (sum2 >= 64) && (sum2 <= 65), 1);

    // Load 200 while frozen; dn holds and valid is low across the load edge
    last2 = int'(dn2);
    load_f(8'd200);
    chk("load_frozen_dn2", dn2, last2);
    en = 1'b1;
    sum1 = 0;
    sum2 = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      sum1 += int'(dn1);
      sum2 += int'(dn2);
    end
    chk("f200_sum1", sum1, 200);
    chk("f200_sum2_in_range", (sum2 >= 199) && (sum2 <= 201), 1);

    // f = 255 with dither: output ranges and carry totals against an LFSR model
    pulse_reset();
    load_f(8'd255);
    dither_en = 1'b1;
    en = 1'b1;
    lfsr = 16'hACE1;
    dcount = 0;
    sum1 = 0;
    sum2 = 0;
    sum3 = 0;
    sum4 = 0;
    for (int i = 0; i < 2048; i++) begin
      dcount += int'(lfsr[0]);
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      tick();
      sum1 += int'(dn1);
      sum2 += int'(dn2);
      sum3 += int'(dn3);
      sum4 += int'(dn4);
      chk("dith_range2", (dn2 >= -1) && (dn2 <= 2), 1);
      chk("dith_range3", (dn3 >= -3) && (dn3 <= 4), 1);
      chk("dith_range4", (dn4 >= -7) && (dn4 <= 8), 1);
    end
    c1sum = (2048 * 255 + dcount) / 256;
    chk("dith_sum1", sum1, c1sum);
    chk("dith_sum2_in_range", (sum2 >= c1sum) && (sum2 <= c1sum + 1), 1);
    chk("dith_sum3_in_range", (sum3 >= c1sum - 1) && (sum3 <= c1sum + 2), 1);
    chk("dith_sum4_in_range", (sum4 >= c1sum - 3) && (sum4 <= c1sum + 4), 1);
    chk("dith_sum4_mean", (sum4 >= 2032) && (sum4 <= 2048), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
